hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed exe/mem/wb stall tracking in the control path.
- Tracks destination register, write enable, load and CSR flags for each in-flight instruction across DEPTH post-decode stages.
- Produces the decode-stage interlock (dec_stall) and per-operand bypass selects.
- Sits in the control path between the decoder and the datapath bypass muxes; also counts stall cycles for performance monitoring.

Parameters:
- ADDR_W, 5, register address width.
- DEPTH, 3, number of tracked post-decode stages (stage 0 = exe, DEPTH-1 = wb); legal range 2..8.
- LOAD_LAT, 1, number of leading stages in which a load result is not yet available (1..DEPTH-1).
- SEL_W, $clog2(DEPTH+1), width of bypass select.
- CNT_W, 32, stall counter width.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- dec_valid  input  1  decode holds a valid instruction
- dec_rs1_addr  input  ADDR_W  decode source 1
- dec_rs2_addr  input  ADDR_W  decode source 2
- dec_rs1_oen  input  1  source 1 used
- dec_rs2_oen  input  1  source 2 used
- dec_wb_addr  input  ADDR_W  decode destination
- dec_rf_wen  input  1  decode writes register file
- dec_is_load  input  1  decode instruction is a load
- dec_is_csr  input  1  decode instruction is a CSR op
- dec_kill  input  1  branch kill of decode instruction
- cmiss_stall  input  1  memory miss; freeze all stages
- dec_stall  output  1  hazard interlock to decode/fetch
- fwd_sel_rs1  output  SEL_W  0 = register file, k = bypass from stage k-1
- fwd_sel_rs2  output  SEL_W  same for rs2
- stall_cnt  output  CNT_W  saturating count of dec_stall cycles

Behaviour:
- Clock and reset: one clock clk. Reset is asynchronous, active-high.
- Reset state: all stage entries cleared (wen=0, addr=0, load=0, csr=0). stall_cnt=0. Therefore dec_stall=0 and fwd_sel_*=0 immediately on reset assertion.
- State: DEPTH entries {wen, addr, is_load, is_csr}. Outputs are combinational from entries and decode inputs; no added latency.
- Match rule: stage s matches rsN iff rsN_oen && entry[s].wen && entry[s].addr==rsN_addr && rsN_addr!=0. x0 never hazards or forwards.
- Hazard: dec_stall = dec_valid && !dec_kill && (any rsN matching stage s<LOAD_LAT with is_load, or entry[0].is_csr).
- Advance, when cmiss_stall=1: all entries hold. stall_cnt does not increment. cmiss_stall has priority over every other event.
- Advance, when cmiss_stall=0: entry[s] <= entry[s-1] for s>=1; the last entry retires.
- Insertion into entry[0]:
  - dec_kill=1, dec_stall=1, or dec_valid=0: a bubble (all zeros).
  - Otherwise: {dec_rf_wen, dec_wb_addr, dec_is_load, dec_is_csr}.
  - dec_kill and dec_stall together: kill wins, bubble inserted, dec_stall forced 0.
- Bypass: fwd_sel_rsN = 1 + s for the smallest matching s (youngest producer wins). 0 if no match, or if dec_stall=1.
- Counter: stall_cnt increments by 1 on each clock where dec_stall=1 and cmiss_stall=0. It saturates at all-ones and never wraps.
- Reset mid-operation: all in-flight entries are discarded immediately. No stall may persist past reset.

Optional Feature:
- Macro: HAZARD_FORWARDING_EN.
- Defined: behaviour as above; non-load matches are bypassed.
- Undefined: full interlock.
  - dec_stall asserts on any match in any stage except the final stage, which writes back in the same cycle.
  - fwd_sel_rs1 and fwd_sel_rs2 are tied to 0.
  - LOAD_LAT is ignored.

Test Plan:
- Reset with entries populated: assert reset mid-stream -> dec_stall=0, fwd_sel=0, stall_cnt=0 in the same cycle; first insert after release is tracked normally.
- Load-use, DEPTH=3, LOAD_LAT=1: LW x5 then ADD x6,x5,x1 -> dec_stall=1 for exactly 1 cycle, bubble in exe; next cycle fwd_sel_rs1=2 (mem); stall_cnt=1.
- ALU bypass: ADDI x3 then SUB x4,x3,x3 -> dec_stall=0, fwd_sel_rs1=fwd_sel_rs2=1. With macro undefined: stall 2 cycles, fwd_sel=0.
- Youngest wins and x0: ADDI x7; ADDI x7; ADD x8,x7,x0 -> fwd_sel_rs1=1, fwd_sel_rs2=0; an instruction writing x0 with rf_wen=1 never stalls or forwards.
- cmiss freeze: LW x5 in exe, then cmiss_stall held 4 cycles -> entries unchanged, dec_stall held at 1, stall_cnt unchanged; after release it increments once and the pipeline advances.
- Kill/CSR and saturation: CSRRW in exe -> dec_stall=1; dec_kill together with a load-use hazard -> dec_stall=0 and bubble inserted; stall_cnt with CNT_W=4 after 20 stall cycles -> 15.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the decoder and the hazard scoreboard.
// master = decoder/pipeline control, slave = scoreboard.
interface hazard_scoreboard_if #(
    parameter int ADDR_W = 5,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 32
);
    logic              dec_valid;
    logic [ADDR_W-1:0] dec_rs1_addr;
    logic [ADDR_W-1:0] dec_rs2_addr;
    logic              dec_rs1_oen;
    logic              dec_rs2_oen;
    logic [ADDR_W-1:0] dec_wb_addr;
    logic              dec_rf_wen;
    logic              dec_is_load;
    logic              dec_is_csr;
    logic              dec_kill;
    logic              cmiss_stall;
    logic              dec_stall;
    logic [SEL_W-1:0]  fwd_sel_rs1;
    logic [SEL_W-1:0]  fwd_sel_rs2;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output dec_valid, dec_rs1_addr, dec_rs2_addr, dec_rs1_oen, dec_rs2_oen,
               dec_wb_addr, dec_rf_wen, dec_is_load, dec_is_csr, dec_kill, cmiss_stall,
        input  dec_stall, fwd_sel_rs1, fwd_sel_rs2, stall_cnt
    );

    modport slave (
        input  dec_valid, dec_rs1_addr, dec_rs2_addr, dec_rs1_oen, dec_rs2_oen,
               dec_wb_addr, dec_rf_wen, dec_is_load, dec_is_csr, dec_kill, cmiss_stall,
        output dec_stall, fwd_sel_rs1, fwd_sel_rs2, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks DEPTH post-decode stages, drives decode interlock and bypass selects.
// Latency: outputs combinational from tracked entries and decode inputs; entries shift each clock.
// Backpressure: cmiss_stall freezes all entries and the stall counter; HAZARD_FORWARDING_EN enables bypassing.
module hazard_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int SEL_W    = $clog2(DEPTH + 1),
    parameter int CNT_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    hazard_scoreboard_if.slave sb
);

    typedef struct packed {
        logic              wen;
        logic [ADDR_W-1:0] addr;
        logic              is_load;
        logic              is_csr;
    } entry_t;

`ifdef HAZARD_FORWARDING_EN
    localparam int HIT_N = DEPTH;
`else
    // The final stage writes back in the same cycle, so it never needs to be compared.
    localparam int HIT_N = DEPTH - 1;
`endif

    entry_t            ent [DEPTH];
    entry_t            ins;
    logic [HIT_N-1:0]  hit1;
    logic [HIT_N-1:0]  hit2;
    logic              raw;
    logic              stall;
    logic [SEL_W-1:0]  sel1;
    logic [SEL_W-1:0]  sel2;
    logic [CNT_W-1:0]  cnt;

    always_comb begin
        hit1 = '0;
        hit2 = '0;
        for (int s = 0; s < HIT_N; s++) begin
            hit1[s] = sb.dec_rs1_oen && ent[s].wen && (ent[s].addr == sb.dec_rs1_addr)
                      && (sb.dec_rs1_addr != '0);
            hit2[s] = sb.dec_rs2_oen && ent[s].wen && (ent[s].addr == sb.dec_rs2_addr)
                      && (sb.dec_rs2_addr != '0);
        end
    end

    // Without forwarding the load term is subsumed by the full interlock; one expression serves both builds.
    always_comb begin
        raw = ent[0].is_csr;
        for (int s = 0; s < LOAD_LAT; s++) begin
            raw = raw || ((hit1[s] || hit2[s]) && ent[s].is_load);
        end
`ifndef HAZARD_FORWARDING_EN
        for (int s = 0; s < HIT_N; s++) begin
            raw = raw || hit1[s] || hit2[s];
        end
`endif
        stall = sb.dec_valid && !sb.dec_kill && raw;
    end

    always_comb begin
        sel1 = '0;
        sel2 = '0;
`ifdef HAZARD_FORWARDING_EN
        // Walk oldest to youngest so the youngest producer overwrites.
        for (int s = HIT_N - 1; s >= 0; s--) begin
            if (hit1[s]) sel1 = SEL_W'(s + 1);
            if (hit2[s]) sel2 = SEL_W'(s + 1);
        end
        if (stall) begin
            sel1 = '0;
            sel2 = '0;
        end
`endif
    end

    always_comb begin
        ins = '0;
        if (sb.dec_valid && !sb.dec_kill && !stall) begin
            ins.wen     = sb.dec_rf_wen;
            ins.addr    = sb.dec_wb_addr;
            ins.is_load = sb.dec_is_load;
            ins.is_csr  = sb.dec_is_csr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < DEPTH; s++) begin
                ent[s] <= '0;
            end
            cnt <= '0;
        end else if (!sb.cmiss_stall) begin
            ent[0] <= ins;
            for (int s = 1; s < DEPTH; s++) begin
                ent[s] <= ent[s-1];
            end
            if (stall && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign sb.dec_stall   = stall;
    assign sb.fwd_sel_rs1 = sel1;
    assign sb.fwd_sel_rs2 = sel2;
    assign sb.stall_cnt   = cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (DEPTH=3, LOAD_LAT=1, CNT_W=4); expectations follow HAZARD_FORWARDING_EN.
module tb_hazard_scoreboard;

`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    hazard_scoreboard_if #(.ADDR_W(5), .SEL_W(2), .CNT_W(4)) sbif ();

    hazard_scoreboard #(
        .ADDR_W(5), .DEPTH(3), .LOAD_LAT(1), .SEL_W(2), .CNT_W(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .sb   (sbif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_dec(input logic v, input logic [4:0] r1, input logic o1,
                           input logic [4:0] r2, input logic o2, input logic [4:0] wb,
                           input logic w, input logic ld, input logic cs);
        sbif.dec_valid    = v;
        sbif.dec_rs1_addr = r1;
        sbif.dec_rs1_oen  = o1;
        sbif.dec_rs2_addr = r2;
        sbif.dec_rs2_oen  = o2;
        sbif.dec_wb_addr  = wb;
        sbif.dec_rf_wen   = w;
        sbif.dec_is_load  = ld;
        sbif.dec_is_csr   = cs;
        sbif.dec_kill     = 1'b0;
    endtask

    task automatic idle();
        set_dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        sbif.cmiss_stall = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        next_cycle();
        set_dec(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (sbif.dec_stall !== 1'b1) begin errors++; $display("FAIL rst_pre_stall got %0b exp 1", sbif.dec_stall); end
        next_cycle();
        checks++; if (sbif.stall_cnt !== 4'd1) begin errors++; $display("FAIL rst_pre_cnt got %0d exp 1", sbif.stall_cnt); end
        reset = 1'b1;
        #1;
        checks++; if (sbif.dec_stall !== 1'b0) begin errors++; $display("FAIL rst_async_stall got %0b exp 0", sbif.dec_stall); end
        checks++; if (sbif.fwd_sel_rs1 !== 2'd0) begin errors++; $display("FAIL rst_async_fwd got %0d exp 0", sbif.fwd_sel_rs1); end
        checks++; if (sbif.stall_cnt !== 4'd0) begin errors++; $display("FAIL rst_async_cnt got %0d exp 0", sbif.stall_cnt); end
        next_cycle();
        reset = 1'b0;
        #1;
        checks++; if (sbif.dec_stall !== 1'b0) begin errors++; $display("FAIL rst_release_stall got %0b exp 0", sbif.dec_stall); end
        set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        next_cycle();
        set_dec(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (sbif.dec_stall !== !FWD) begin errors++; $display("FAIL rst_first_stall got %0b exp %0b", sbif.dec_stall, !FWD); end
        checks++; if (sbif.fwd_sel_rs1 !== (FWD ? 2'd1 : 2'd0)) begin errors++; $display("FAIL rst_first_fwd got %0d exp %0d", sbif.fwd_sel_rs1, FWD ? 1 : 0); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        next_cycle();
        set_dec(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (sbif.dec_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %0b exp 1", sbif.dec_stall); end
        checks++; if (sbif.fwd_sel_rs1 !== 2'd0) begin errors++; $display("FAIL lu_fwd_during_stall got %0d exp 0", sbif.fwd_sel_rs1); end
        next_cycle();
        checks++; if (sbif.dec_stall !== !FWD) begin errors++; $display("FAIL lu_cyc2_stall got %0b exp %0b", sbif.dec_stall, !FWD); end
        checks++; if (sbif.fwd_sel_rs1 !== (FWD ? 2'd2 : 2'd0)) begin errors++; $display("FAIL lu_cyc2_fwd got %0d exp %0d", sbif.fwd_sel_rs1, FWD ? 2 : 0); end
        checks++; if (sbif.stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_cyc2_cnt got %0d exp 1", sbif.stall_cnt); end
        next_cycle();
        checks++; if (sbif.dec_stall !== 1'b0) begin errors++; $display("FAIL lu_cyc3_stall got %0b exp 0", sbif.dec_stall); end
        checks++; if (sbif.fwd_sel_rs1 !== (FWD ? 2'd3 : 2'd0)) begin errors++; $display("FAIL lu_cyc3_fwd got %0d exp %0d", sbif.fwd_sel_rs1, FWD ? 3 : 0); end
        checks++; if (sbif.stall_cnt !== (FWD ? 4'd1 : 4'd2)) begin errors++; $display("FAIL lu_cyc3_cnt got %0d exp %0d", sbif.stall_cnt, FWD ? 1 : 2); end
    endtask

    task automatic test_alu_bypass();
        logic       exp_stall [3];
        logic [1:0] exp_fwd   [3];
        exp_stall = FWD ? '{1'b0, 1'b0, 1'b0} : '{1'b1, 1'b1, 1'b0};
        exp_fwd   = FWD ? '{2'd1, 2'd2, 2'd3} : '{2'd0, 2'd0, 2'd0};
        do_reset();
        set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        next_cycle();
        set_dec(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (sbif.dec_stall !== exp_stall[i]) begin errors++; $display("FAIL alu_stall[%0d] got %0b exp %0b", i, sbif.dec_stall, exp_stall[i]); end
            checks++; if (sbif.fwd_sel_rs1 !== exp_fwd[i] || sbif.fwd_sel_rs2 !== exp_fwd[i]) begin errors++; $display("FAIL alu_fwd[%0d] got %0d/%0d exp %0d", i, sbif.fwd_sel_rs1, sbif.fwd_sel_rs2, exp_fwd[i]); end
            next_cycle();
        end
        checks++; if (sbif.stall_cnt !== (FWD ? 4'd0 : 4'd2)) begin errors++; $display("FAIL alu_cnt got %0d exp %0d", sbif.stall_cnt, FWD ? 0 : 2); end
    endtask

    task automatic test_youngest_x0();
        do_reset();
        set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        next_cycle();
        next_cycle();
        set_dec(1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (sbif.fwd_sel_rs1 !== (FWD ? 2'd1 : 2'd0)) begin errors++; $display("FAIL yw_fwd1 got %0d exp %0d", sbif.fwd_sel_rs1, FWD ? 1 : 0); end
        checks++; if (sbif.fwd_sel_rs2 !== 2'd0) begin errors++; $display("FAIL yw_fwd2 got %0d exp 0", sbif.fwd_sel_rs2); end
        checks++; if (sbif.dec_stall !== !FWD) begin errors++; $display("FAIL yw_stall got %0b exp %0b", sbif.dec_stall, !FWD); end
        do_reset();
        set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        next_cycle();
        set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (sbif.dec_stall !== 1'b0) begin errors++; $display("FAIL x0_stall got %0b exp 0", sbif.dec_stall); end
        checks++; if (sbif.fwd_sel_rs1 !== 2'd0 || sbif.fwd_sel_rs2 !== 2'd0) begin errors++; $display("FAIL x0_fwd got %0d/%0d exp 0/0", sbif.fwd_sel_rs1, sbif.fwd_sel_rs2); end
    endtask

    task automatic test_cmiss();
        do_reset();
        set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        next_cycle();
        set_dec(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        sbif.cmiss_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (sbif.dec_stall !== 1'b1 || sbif.stall_cnt !== 4'd0) begin errors++; $display("FAIL cmiss_hold[%0d] got stall %0b cnt %0d exp stall 1 cnt 0", i, sbif.dec_stall, sbif.stall_cnt); end
            next_cycle();
        end
        sbif.cmiss_stall = 1'b0;
        #1;
        checks++; if (sbif.dec_stall !== 1'b1) begin errors++; $display("FAIL cmiss_release_stall got %0b exp 1", sbif.dec_stall); end
        next_cycle();
        checks++; if (sbif.stall_cnt !== 4'd1) begin errors++; $display("FAIL cmiss_cnt got %0d exp 1", sbif.stall_cnt); end
        checks++; if (sbif.dec_stall !== !FWD) begin errors++; $display("FAIL cmiss_adv_stall got %0b exp %0b", sbif.dec_stall, !FWD); end
        checks++; if (sbif.fwd_sel_rs1 !== (FWD ? 2'd2 : 2'd0)) begin errors++; $display("FAIL cmiss_adv_fwd got %0d exp %0d", sbif.fwd_sel_rs1, FWD ? 2 : 0); end
        next_cycle();
        checks++; if (sbif.dec_stall !== 1'b0) begin errors++; $display("FAIL cmiss_end_stall got %0b exp 0", sbif.dec_stall); end
        checks++; if (sbif.stall_cnt !== (FWD ? 4'd1 : 4'd2)) begin errors++; $display("FAIL cmiss_end_cnt got %0d exp %0d", sbif.stall_cnt, FWD ? 1 : 2); end
    endtask

    task automatic test_kill_csr();
        do_reset();
        set_dec(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1);
        next_cycle();
        set_dec(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (sbif.dec_stall !== 1'b1) begin errors++; $display("FAIL csr_stall got %0b exp 1", sbif.dec_stall); end
        sbif.dec_kill = 1'b1;
        #1;
        checks++; if (sbif.dec_stall !== 1'b0) begin errors++; $display("FAIL csr_kill_stall got %0b exp 0", sbif.dec_stall); end
        next_cycle();
        sbif.dec_kill = 1'b0;
        #1;
        checks++; if (sbif.dec_stall !== 1'b0 || sbif.stall_cnt !== 4'd0) begin errors++; $display("FAIL csr_after got stall %0b cnt %0d exp stall 0 cnt 0", sbif.dec_stall, sbif.stall_cnt); end
        do_reset();
        set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        next_cycle();
        set_dec(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
        sbif.dec_kill = 1'b1;
        #1;
        checks++; if (sbif.dec_stall !== 1'b0) begin errors++; $display("FAIL kill_lu_stall got %0b exp 0", sbif.dec_stall); end
        checks++; if (sbif.fwd_sel_rs1 !== (FWD ? 2'd1 : 2'd0)) begin errors++; $display("FAIL kill_lu_fwd got %0d exp %0d", sbif.fwd_sel_rs1, FWD ? 1 : 0); end
        next_cycle();
        set_dec(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (sbif.dec_stall !== 1'b0 || sbif.fwd_sel_rs1 !== 2'd0) begin errors++; $display("FAIL kill_bubble got stall %0b fwd %0d exp 0/0", sbif.dec_stall, sbif.fwd_sel_rs1); end
        checks++; if (sbif.stall_cnt !== 4'd0) begin errors++; $display("FAIL kill_cnt got %0d exp 0", sbif.stall_cnt); end
    endtask

    task automatic test_saturation();
        do_reset();
        set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        next_cycle();
        set_dec(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        repeat (6) next_cycle();
        checks++; if (sbif.stall_cnt !== (FWD ? 4'd3 : 4'd4)) begin errors++; $display("FAIL sat_partial got %0d exp %0d", sbif.stall_cnt, FWD ? 3 : 4); end
        repeat (34) next_cycle();
        checks++; if (sbif.stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_full got %0d exp 15", sbif.stall_cnt); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle();
        #2;
        checks++; if (sbif.dec_stall !== 1'b0 || sbif.stall_cnt !== 4'd0 || sbif.fwd_sel_rs1 !== 2'd0) begin errors++; $display("FAIL por_state got stall %0b cnt %0d fwd %0d exp 0/0/0", sbif.dec_stall, sbif.stall_cnt, sbif.fwd_sel_rs1); end
        test_reset();
        test_load_use();
        test_alu_bypass();
        test_youngest_x0();
        test_cmiss();
        test_kill_csr();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
